// File: rtl/rps_defs.sv
// Shared definitions for the rock-paper-scissors VGA path: sprite IDs, colours,
// screen size and the sprite_blitter FSM encoding.
package rps_defs;

    typedef enum logic [1:0] {
        ROCK    = 2'd0,
        SCISSOR = 2'd1,
        PAPER   = 2'd2
    } sprite_id_t;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] WHITE = 3'b111;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } blit_state_t;

endpackage

// File: rtl/sprite_blitter_if.sv
// Bundle between the game controller / ROM mux (master) and sprite_blitter (slave):
// draw request, ROM read port and the plot stream towards the vga_adapter.
interface sprite_blitter_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SPR_W    = 32,
    parameter int SPR_H    = 32,
    parameter int NUM_SPR  = 3,
    parameter int COLOUR_W = 3
);
    localparam int SEL_W  = $clog2(NUM_SPR);
    localparam int ADDR_W = $clog2(SPR_W * SPR_H);

    logic                start;
    logic [SEL_W-1:0]    sprite_sel;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [COLOUR_W-1:0] fg_colour;
    logic [COLOUR_W-1:0] bg_colour;
    logic                transparent;
    logic [SEL_W-1:0]    rom_sel;
    logic [ADDR_W-1:0]   rom_addr;
    logic                rom_q;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                busy;
    logic                done;

    modport master (
        output start, sprite_sel, x0, y0, fg_colour, bg_colour, transparent, rom_q,
        input  rom_sel, rom_addr, x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, sprite_sel, x0, y0, fg_colour, bg_colour, transparent, rom_q,
        output rom_sel, rom_addr, x, y, colour, plot, busy, done
    );

endinterface

// File: rtl/blit_scan_ctr.sv
// Sprite scan counters: sx runs 0..SPR_W-1 and wraps into sy; o_last flags the
// final pixel (SPR_W-1, SPR_H-1).
module blit_scan_ctr #(
    parameter int SPR_W = 32,
    parameter int SPR_H = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_en,
    output logic [$clog2(SPR_W)-1:0] o_sx,
    output logic [$clog2(SPR_H)-1:0] o_sy,
    output logic                     o_last
);
    localparam int SX_W = $clog2(SPR_W);
    localparam int SY_W = $clog2(SPR_H);

    logic [SX_W-1:0] r_sx;
    logic [SY_W-1:0] r_sy;
    logic            w_row_end;

    assign w_row_end = (r_sx == SX_W'(SPR_W - 1));
    assign o_last    = w_row_end && (r_sy == SY_W'(SPR_H - 1));
    assign o_sx      = r_sx;
    assign o_sy      = r_sy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sx <= '0;
            r_sy <= '0;
        end else if (i_clr) begin
            r_sx <= '0;
            r_sy <= '0;
        end else if (i_en) begin
            if (w_row_end) begin
                r_sx <= '0;
                r_sy <= o_last ? '0 : r_sy + 1'b1;
            end else begin
                r_sx <= r_sx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite drawing engine: scans one SPR_W x SPR_H monochrome sprite from ROM and
// emits clipped (x, y, colour, plot) writes, aligned to the one-cycle ROM latency.
module sprite_blitter
    import rps_defs::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SPR_W    = 32,
    parameter int SPR_H    = 32,
    parameter int NUM_SPR  = 3,
    parameter int COLOUR_W = 3
) (
    input logic              CLOCK_50,
    input logic              reset_n,
    sprite_blitter_if.slave  bus
);
    localparam int SEL_W  = $clog2(NUM_SPR);
    localparam int SX_W   = $clog2(SPR_W);
    localparam int SY_W   = $clog2(SPR_H);
    localparam int ADDR_W = $clog2(SPR_W * SPR_H);

    blit_state_t         r_state;
    logic                r_drain;
    logic                r_busy;
    logic                r_done;
    logic [SEL_W-1:0]    r_sel;
    logic [X_W-1:0]      r_x0;
    logic [Y_W-1:0]      r_y0;
    logic [COLOUR_W-1:0] r_fg;
    logic [COLOUR_W-1:0] r_bg;
    logic                r_transp;

    logic [SX_W-1:0]     w_sx;
    logic [SY_W-1:0]     w_sy;
    logic                w_last;
    logic                w_clr;
    logic                w_en;
    logic [X_W:0]        w_x_sum;
    logic [Y_W:0]        w_y_sum;

    logic                r_vld_p1;
    logic [SX_W-1:0]     r_sx_p1;
    logic [SY_W-1:0]     r_sy_p1;
    logic [X_W-1:0]      r_x_p2;
    logic [Y_W-1:0]      r_y_p2;
    logic [COLOUR_W-1:0] r_colour_p2;
    logic                r_plot_p2;

    function automatic logic [SEL_W-1:0] legal_sel(input logic [SEL_W-1:0] sel);
        return (32'(sel) < NUM_SPR) ? sel : '0;
    endfunction

    // Sums are one bit wider than the screen coordinate so off-screen pixels are dropped, not wrapped.
    function automatic logic on_screen(input logic [X_W:0] xs, input logic [Y_W:0] ys);
        return (xs < (X_W+1)'(SCREEN_W)) && (ys < (Y_W+1)'(SCREEN_H));
    endfunction

    assign w_clr = (r_state == IDLE) && bus.start;
    assign w_en  = (r_state == SCAN);

    blit_scan_ctr #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_scan_ctr (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset_n),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_sx    (w_sx),
        .o_sy    (w_sy),
        .o_last  (w_last)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_drain <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sel   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_sel   <= legal_sel(bus.sprite_sel);
                    r_busy  <= 1'b1;
                    r_state <= SCAN;
                end
                SCAN: if (w_last) begin
                    r_drain <= 1'b0;
                    r_state <= DRAIN;
                end
                DRAIN: if (r_drain) begin
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end else begin
                    r_drain <= 1'b1;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_clr) begin
            r_x0     <= bus.x0;
            r_y0     <= bus.y0;
            r_fg     <= bus.fg_colour;
            r_bg     <= bus.bg_colour;
            r_transp <= bus.transparent;
        end
    end

    // Stage 1: pixel coordinates travel alongside the ROM read
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) r_vld_p1 <= 1'b0;
        else          r_vld_p1 <= w_en;
    end

    always_ff @(posedge CLOCK_50) begin
        r_sx_p1 <= w_sx;
        r_sy_p1 <= w_sy;
    end

    assign w_x_sum = {1'b0, r_x0} + (X_W+1)'(r_sx_p1);
    assign w_y_sum = {1'b0, r_y0} + (Y_W+1)'(r_sy_p1);

    // Stage 2: rom_q is valid here; register the plot write
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_x_p2      <= '0;
            r_y_p2      <= '0;
            r_colour_p2 <= '0;
            r_plot_p2   <= 1'b0;
        end else begin
            r_x_p2      <= w_x_sum[X_W-1:0];
            r_y_p2      <= w_y_sum[Y_W-1:0];
            r_colour_p2 <= bus.rom_q ? r_fg : r_bg;
            r_plot_p2   <= r_vld_p1 && on_screen(w_x_sum, w_y_sum) && !(r_transp && !bus.rom_q);
        end
    end

    assign bus.rom_sel  = r_sel;
    assign bus.rom_addr = ADDR_W'(w_sy) * ADDR_W'(SPR_W) + ADDR_W'(w_sx);
    assign bus.x        = r_x_p2;
    assign bus.y        = r_y_p2;
    assign bus.colour   = r_colour_p2;
    assign bus.plot     = r_plot_p2;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a 4x4 sprite: table of draw jobs checked
// cycle by cycle, plus hand-written start-while-busy and mid-draw reset sequences.
module tb_sprite_blitter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sprite_blitter_if #(.SPR_W(4), .SPR_H(4)) bus ();

    sprite_blitter #(.SPR_W(4), .SPR_H(4)) dut (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite images, bit k = pixel (k%4, k/4): checkerboard, all ones, diagonal
    logic [15:0] rom_img [3];
    initial begin
        rom_img[0] = 16'hA5A5;
        rom_img[1] = 16'hFFFF;
        rom_img[2] = 16'h8421;
    end

    always @(posedge clk) begin
        logic [15:0] img;
        img = (bus.rom_sel < 2'd3) ? rom_img[bus.rom_sel] : 16'h0000;
        bus.rom_q <= img[bus.rom_addr];
    end

    typedef struct {
        logic [1:0] sel;
        logic [7:0] x0;
        logic [6:0] y0;
        logic [2:0] fg;
        logic [2:0] bg;
        logic       tr;
        logic [1:0] exp_sel;
        int         exp_plots;
    } job_t;

    job_t jobs [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.sprite_sel  = 2'd1;
        bus.x0          = 8'd0;
        bus.y0          = 7'd0;
        bus.fg_colour   = 3'd0;
        bus.bg_colour   = 3'd0;
        bus.transparent = 1'b0;
    endtask

    // Runs one job from cycle 0 (start sampled) to cycle 20 (idle again)
    task automatic run_job(input int idx);
        job_t        j;
        logic [15:0] img;
        int          plots;
        int          k;
        int          xs;
        int          ys;
        logic        b;
        logic        ep;
        j = jobs[idx];
        img = rom_img[j.exp_sel];
        plots = 0;
        bus.start       = 1'b1;
        bus.sprite_sel  = j.sel;
        bus.x0          = j.x0;
        bus.y0          = j.y0;
        bus.fg_colour   = j.fg;
        bus.bg_colour   = j.bg;
        bus.transparent = j.tr;
        step();
        bus.start       = 1'b0;
        bus.sprite_sel  = ~j.sel;
        bus.x0          = ~j.x0;
        bus.y0          = ~j.y0;
        bus.fg_colour   = ~j.fg;
        bus.bg_colour   = ~j.bg;
        bus.transparent = ~j.tr;
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("job%0d busy c%0d", idx, c), 32'(bus.busy), 32'(c <= 19));
            chk($sformatf("job%0d done c%0d", idx, c), 32'(bus.done), 32'(c == 19));
            if (c <= 19)
                chk($sformatf("job%0d rom_sel c%0d", idx, c), 32'(bus.rom_sel), 32'(j.exp_sel));
            if (c <= 16)
                chk($sformatf("job%0d rom_addr c%0d", idx, c), 32'(bus.rom_addr), 32'(c - 1));
            ep = 1'b0;
            b  = 1'b0;
            xs = 0;
            ys = 0;
            if (c >= 3 && c <= 18) begin
                k  = c - 3;
                b  = img[k];
                xs = int'(j.x0) + (k % 4);
                ys = int'(j.y0) + (k / 4);
                ep = (xs < 160) && (ys < 120) && !(j.tr && !b);
            end
            chk($sformatf("job%0d plot c%0d", idx, c), 32'(bus.plot), 32'(ep));
            if (bus.plot) plots++;
            if (ep) begin
                chk($sformatf("job%0d x c%0d", idx, c), 32'(bus.x), 32'(xs));
                chk($sformatf("job%0d y c%0d", idx, c), 32'(bus.y), 32'(ys));
                chk($sformatf("job%0d colour c%0d", idx, c), 32'(bus.colour), 32'(b ? j.fg : j.bg));
            end
            step();
        end
        chk($sformatf("job%0d plot count", idx), 32'(plots), 32'(j.exp_plots));
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int plots;
        int waited;
        total = 0;
        bad   = 0;
        jobs[0] = '{sel: 2'd0, x0: 8'd10,  y0: 7'd20,  fg: 3'd7, bg: 3'd2, tr: 1'b0, exp_sel: 2'd0, exp_plots: 16};
        jobs[1] = '{sel: 2'd0, x0: 8'd10,  y0: 7'd20,  fg: 3'd7, bg: 3'd2, tr: 1'b1, exp_sel: 2'd0, exp_plots: 8};
        jobs[2] = '{sel: 2'd1, x0: 8'd158, y0: 7'd118, fg: 3'd7, bg: 3'd3, tr: 1'b0, exp_sel: 2'd1, exp_plots: 4};
        jobs[3] = '{sel: 2'd3, x0: 8'd0,   y0: 7'd0,   fg: 3'd6, bg: 3'd1, tr: 1'b1, exp_sel: 2'd0, exp_plots: 8};
        jobs[4] = '{sel: 2'd2, x0: 8'd157, y0: 7'd0,   fg: 3'd4, bg: 3'd2, tr: 1'b0, exp_sel: 2'd2, exp_plots: 12};
        jobs[5] = '{sel: 2'd2, x0: 8'd40,  y0: 7'd100, fg: 3'd3, bg: 3'd0, tr: 1'b1, exp_sel: 2'd2, exp_plots: 4};
        jobs[6] = '{sel: 2'd2, x0: 8'd0,   y0: 7'd118, fg: 3'd5, bg: 3'd6, tr: 1'b0, exp_sel: 2'd2, exp_plots: 8};

        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        chk("reset plot", 32'(bus.plot), 32'(0));
        chk("reset busy", 32'(bus.busy), 32'(0));
        chk("reset done", 32'(bus.done), 32'(0));
        chk("reset x", 32'(bus.x), 32'(0));
        chk("reset y", 32'(bus.y), 32'(0));
        chk("reset colour", 32'(bus.colour), 32'(0));
        chk("reset rom_addr", 32'(bus.rom_addr), 32'(0));
        chk("reset rom_sel", 32'(bus.rom_sel), 32'(0));
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_job(i);

        // start at cycles 5 and 19 ignored; start at 20 accepted
        bus.start = 1'b1; bus.sprite_sel = 2'd0; bus.x0 = 8'd10; bus.y0 = 7'd20;
        bus.fg_colour = 3'd7; bus.bg_colour = 3'd2; bus.transparent = 1'b0;
        step();
        plots = 0;
        for (int c = 1; c <= 20; c++) begin
            bus.start = (c == 5 || c == 19 || c == 20);
            if (bus.plot) plots++;
            if (c == 19) chk("reissue done c19", 32'(bus.done), 32'(1));
            if (c == 20) chk("reissue busy c20", 32'(bus.busy), 32'(0));
            if (c == 6)  chk("reissue busy c6", 32'(bus.busy), 32'(1));
            if (c == 6)  chk("reissue rom_addr c6", 32'(bus.rom_addr), 32'(5));
            step();
        end
        bus.start = 1'b0;
        chk("reissue plot count", 32'(plots), 32'(16));
        chk("restart busy c21", 32'(bus.busy), 32'(1));
        chk("restart rom_addr c21", 32'(bus.rom_addr), 32'(0));
        waited = 0;
        while (!bus.done && waited < 40) begin
            step();
            waited++;
        end
        chk("restart done latency", 32'(waited), 32'(18));
        step();
        step();

        // Asynchronous reset mid-draw at cycle 7
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 7; c++) step();
        chk("pre-reset plot c7", 32'(bus.plot), 32'(1));
        chk("pre-reset busy c7", 32'(bus.busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("async reset plot", 32'(bus.plot), 32'(0));
        chk("async reset busy", 32'(bus.busy), 32'(0));
        chk("async reset done", 32'(bus.done), 32'(0));
        step();
        step();
        rst_n = 1'b1;
        plots = 0;
        for (int c = 0; c < 24; c++) begin
            if (bus.plot) plots++;
            if (bus.busy || bus.done) plots += 100;
            step();
        end
        chk("post-reset quiet", 32'(plots), 32'(0));
        idle_inputs();
        run_job(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
